// File: rtl/neurosync_pkg.sv
// Shared types and helpers for the neurosync player-input front end.
package neurosync_pkg;

  localparam int unsigned NUM_BOTOES = 4;

  typedef enum logic [2:0] {
    Ocioso     = 3'd0,
    Estabiliza = 3'd1,
    Avalia     = 3'd2,
    Segurado   = 3'd3,
    Solta      = 3'd4
  } estado_t;

  function automatic int unsigned popcount(input logic [NUM_BOTOES-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_BOTOES; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit 2-flop synchroniser plus stability counter; nivel is the clean level.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic nivel
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CntFim = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sinc_q;
  logic          nivel_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sinc_q  <= 1'b0;
      nivel_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q <= entrada;
      sinc_q <= meta_q;
      // The counter only runs while the synchronised input disagrees with the accepted level.
      if (sinc_q == nivel_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntFim) begin
        nivel_q <= sinc_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign nivel = nivel_q;

endmodule

// File: rtl/captura_jogada.sv
// Player-input front end: debounces the play buttons and control keys and emits clean
// single-cycle events for the game core.
module captura_jogada
  import neurosync_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_BOTOES-1:0] botoes,
  input  logic                  mais,
  input  logic                  menos,
  input  logic                  confirma,
  output logic [NUM_BOTOES-1:0] jogada,
  output logic                  tem_jogada,
  output logic                  jogada_invalida,
  output logic                  mais_pulso,
  output logic                  menos_pulso,
  output logic                  confirma_pulso,
  output logic [2:0]            db_estado
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CntFim = CW'(DEBOUNCE_CYCLES - 1);

  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam logic [RW-1:0] AtrasoFim  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PeriodoFim = RW'(REPEAT_PERIOD - 1);

  // Play FSM
  logic [NUM_BOTOES-1:0] botoes_meta_q;
  logic [NUM_BOTOES-1:0] s_botoes;
  logic [NUM_BOTOES-1:0] vec_q;
  logic [NUM_BOTOES-1:0] jogada_q;
  logic [CW-1:0]         cnt_q;
  estado_t               estado_q;
  logic                  tem_jogada_q;
  logic                  invalida_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      botoes_meta_q <= '0;
      s_botoes      <= '0;
      vec_q         <= '0;
      jogada_q      <= '0;
      cnt_q         <= '0;
      estado_q      <= Ocioso;
      tem_jogada_q  <= 1'b0;
      invalida_q    <= 1'b0;
    end else begin
      botoes_meta_q <= botoes;
      s_botoes      <= botoes_meta_q;
      tem_jogada_q  <= 1'b0;
      invalida_q    <= 1'b0;
      unique case (estado_q)
        Ocioso: begin
          if (s_botoes != '0) begin
            vec_q    <= s_botoes;
            cnt_q    <= '0;
            estado_q <= Estabiliza;
          end
        end
        Estabiliza: begin
          if (s_botoes == '0) begin
            estado_q <= Ocioso;
          end else if (s_botoes != vec_q) begin
            vec_q <= s_botoes;
            cnt_q <= '0;
          end else if (cnt_q == CntFim) begin
            // Verdict is registered on entry to Avalia so the pulse is visible during Avalia.
            estado_q <= Avalia;
            if (popcount(vec_q) == 1) begin
              if (enable) begin
                jogada_q     <= vec_q;
                tem_jogada_q <= 1'b1;
              end
            end else begin
              invalida_q <= enable;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        Avalia: begin
          estado_q <= Segurado;
        end
        Segurado: begin
          if (s_botoes == '0) begin
            cnt_q    <= '0;
            estado_q <= Solta;
          end
        end
        Solta: begin
          if (s_botoes != '0) begin
            estado_q <= Segurado;
          end else if (cnt_q == CntFim) begin
            estado_q <= Ocioso;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: estado_q <= Ocioso;
      endcase
    end
  end

  // Control keys
  logic mais_nivel, menos_nivel, confirma_nivel;

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mais (
    .clock   (clock),
    .reset   (reset),
    .entrada (mais),
    .nivel   (mais_nivel)
  );

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_menos (
    .clock   (clock),
    .reset   (reset),
    .entrada (menos),
    .nivel   (menos_nivel)
  );

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirma (
    .clock   (clock),
    .reset   (reset),
    .entrada (confirma),
    .nivel   (confirma_nivel)
  );

  // Index 0 is mais, index 1 is menos.
  logic [1:0]    rep_nivel;
  logic [1:0]    rep_prev_q;
  logic [1:0]    rep_fase_q;
  logic [1:0]    rep_pulso_q;
  logic [RW-1:0] rep_cnt_q [2];
  logic          conf_prev_q;
  logic          conf_pulso_q;

  assign rep_nivel = {menos_nivel, mais_nivel};

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_prev_q   <= '0;
      rep_fase_q   <= '0;
      rep_pulso_q  <= '0;
      conf_prev_q  <= 1'b0;
      conf_pulso_q <= 1'b0;
      for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
    end else begin
      conf_prev_q  <= confirma_nivel;
      conf_pulso_q <= confirma_nivel & ~conf_prev_q;
      for (int i = 0; i < 2; i++) begin
        rep_prev_q[i] <= rep_nivel[i];
        // Counters run ungated by enable so repeats resume on the next boundary.
        if (!(rep_nivel[i] && rep_prev_q[i])) begin
          rep_cnt_q[i]   <= '0;
          rep_fase_q[i]  <= 1'b0;
          rep_pulso_q[i] <= rep_nivel[i];
        end else if (rep_cnt_q[i] == (rep_fase_q[i] ? PeriodoFim : AtrasoFim)) begin
          rep_cnt_q[i]   <= '0;
          rep_fase_q[i]  <= 1'b1;
          rep_pulso_q[i] <= 1'b1;
        end else begin
          rep_cnt_q[i]   <= rep_cnt_q[i] + RW'(1);
          rep_pulso_q[i] <= 1'b0;
        end
      end
    end
  end

  assign jogada          = jogada_q;
  assign tem_jogada      = tem_jogada_q & enable;
  assign jogada_invalida = invalida_q & enable;
  assign mais_pulso      = rep_pulso_q[0] & enable;
  assign menos_pulso     = rep_pulso_q[1] & enable;
  assign confirma_pulso  = conf_pulso_q & enable;
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_captura_jogada.sv
// Directed bench for captura_jogada with short debounce and repeat timings.
module tb_captura_jogada;

  logic       clock = 1'b0;
  logic       reset, enable, mais, menos, confirma;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       tem_jogada, jogada_invalida, mais_pulso, menos_pulso, confirma_pulso;
  logic [2:0] db_estado;

  int passed = 0;
  int total  = 0;

  // Per-run observations collected by run()
  int          n_tem, n_inv, n_mais, n_menos, n_conf, first_tem, first_conf;
  logic [63:0] mais_mask;

  always #5 clock = ~clock;

  captura_jogada #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .botoes          (botoes),
    .mais            (mais),
    .menos           (menos),
    .confirma        (confirma),
    .jogada          (jogada),
    .tem_jogada      (tem_jogada),
    .jogada_invalida (jogada_invalida),
    .mais_pulso      (mais_pulso),
    .menos_pulso     (menos_pulso),
    .confirma_pulso  (confirma_pulso),
    .db_estado       (db_estado)
  );

  // Tick k is the k-th rising edge after the inputs were last changed; samples land 1 ns later.
  task automatic run(input int n);
    n_tem = 0; n_inv = 0; n_mais = 0; n_menos = 0; n_conf = 0;
    first_tem = 0; first_conf = 0; mais_mask = '0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      #1;
      if (tem_jogada) begin
        n_tem++;
        if (first_tem == 0) first_tem = k;
      end
      if (jogada_invalida) n_inv++;
      if (mais_pulso) begin
        n_mais++;
        if (k < 64) mais_mask[k] = 1'b1;
      end
      if (menos_pulso) n_menos++;
      if (confirma_pulso) begin
        n_conf++;
        if (first_conf == 0) first_conf = k;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; botoes = 4'b0000; mais = 0; menos = 0; confirma = 0;
    run(3);
    total++;
    if (jogada !== 4'b0000) $display("FAIL reset_jogada: got %b expected 0000", jogada);
    else passed++;
    total++;
    if ({tem_jogada, jogada_invalida, mais_pulso, menos_pulso, confirma_pulso} !== 5'b0)
      $display("FAIL reset_pulses: got %b expected 00000",
               {tem_jogada, jogada_invalida, mais_pulso, menos_pulso, confirma_pulso});
    else passed++;
    total++;
    if (db_estado !== 3'd0) $display("FAIL reset_estado: got %0d expected 0", db_estado);
    else passed++;
    reset = 1'b0;
    run(2);
  endtask

  task automatic test_clean_press();
    botoes = 4'b0010;
    run(20);
    total++;
    if (n_tem !== 1) $display("FAIL clean_count: got %0d expected 1", n_tem);
    else passed++;
    total++;
    if (first_tem !== 7) $display("FAIL clean_latency: got tick %0d expected tick 7", first_tem);
    else passed++;
    total++;
    if (jogada !== 4'b0010) $display("FAIL clean_jogada: got %b expected 0010", jogada);
    else passed++;
    total++;
    if (db_estado !== 3'd3) $display("FAIL clean_segurado: got %0d expected 3", db_estado);
    else passed++;
    // Release: 2 sync edges, 1 edge into Solta, then 4 counted edges.
    botoes = 4'b0000;
    run(6);
    total++;
    if (db_estado !== 3'd4) $display("FAIL release_solta: got %0d expected 4", db_estado);
    else passed++;
    run(1);
    total++;
    if (db_estado !== 3'd0) $display("FAIL release_ocioso: got %0d expected 0", db_estado);
    else passed++;
    run(5);
    total++;
    if (n_tem + n_inv !== 0) $display("FAIL release_quiet: got %0d pulses expected 0", n_tem + n_inv);
    else passed++;
  endtask

  task automatic test_bounce();
    int bounced;
    bounced = 0;
    for (int i = 0; i < 5; i++) begin
      botoes = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      run(2);
      bounced += n_tem + n_inv;
    end
    total++;
    if (bounced !== 0) $display("FAIL bounce_quiet: got %0d events expected 0", bounced);
    else passed++;
    botoes = 4'b0100;
    run(20);
    total++;
    if (n_tem !== 1) $display("FAIL bounce_count: got %0d expected 1", n_tem);
    else passed++;
    total++;
    if (jogada !== 4'b0100) $display("FAIL bounce_jogada: got %b expected 0100", jogada);
    else passed++;
    botoes = 4'b0000;
    run(10);
  endtask

  task automatic test_invalid();
    botoes = 4'b1001;
    run(10);
    total++;
    if (n_inv !== 1) $display("FAIL invalid_count: got %0d expected 1", n_inv);
    else passed++;
    total++;
    if (n_tem !== 0) $display("FAIL invalid_no_play: got %0d expected 0", n_tem);
    else passed++;
    total++;
    if (jogada !== 4'b0100) $display("FAIL invalid_hold: got %b expected 0100", jogada);
    else passed++;
    botoes = 4'b0000;
    run(10);
  endtask

  task automatic test_auto_repeat();
    logic [63:0] exp_mask;
    logic [63:0] mask_hold;
    int          n_menos_hold;
    int          ticks [8] = '{7, 17, 20, 23, 26, 29, 32, 35};
    exp_mask = '0;
    // The clean level stays high 5 edges past the raw release, so repeats at 32 and 35 still fire.
    foreach (ticks[i]) exp_mask[ticks[i]] = 1'b1;
    mais = 1'b1;
    run(30);
    mask_hold    = mais_mask;
    n_menos_hold = n_menos + n_conf;
    mais = 1'b0;
    run(20);
    mask_hold = mask_hold | (mais_mask << 30);
    total++;
    if (mask_hold !== exp_mask) $display("FAIL repeat_ticks: got %h expected %h", mask_hold, exp_mask);
    else passed++;
    total++;
    if (n_menos_hold + n_menos + n_conf !== 0)
      $display("FAIL repeat_other_keys: got %0d expected 0", n_menos_hold + n_menos + n_conf);
    else passed++;
  endtask

  task automatic test_simultaneous();
    botoes = 4'b0010; confirma = 1'b1;
    run(20);
    total++;
    if (n_conf !== 1) $display("FAIL confirma_count: got %0d expected 1", n_conf);
    else passed++;
    total++;
    if (first_conf !== 7 || first_tem !== 7)
      $display("FAIL simultaneous_tick: got conf %0d play %0d expected 7 7", first_conf, first_tem);
    else passed++;
    total++;
    if (jogada !== 4'b0010) $display("FAIL simultaneous_jogada: got %b expected 0010", jogada);
    else passed++;
    botoes = 4'b0000; confirma = 1'b0;
    run(10);
  endtask

  task automatic test_enable_gating();
    int n_total;
    enable = 1'b0; botoes = 4'b0001;
    run(12);
    n_total = n_tem;
    enable = 1'b1;
    run(12);
    n_total += n_tem;
    total++;
    if (n_total !== 0) $display("FAIL gated_no_play: got %0d expected 0", n_total);
    else passed++;
    total++;
    if (jogada !== 4'b0010) $display("FAIL gated_jogada: got %b expected 0010", jogada);
    else passed++;
    botoes = 4'b0000;
    run(10);
    botoes = 4'b0001;
    run(12);
    total++;
    if (n_tem !== 1) $display("FAIL repress_count: got %0d expected 1", n_tem);
    else passed++;
    total++;
    if (jogada !== 4'b0001) $display("FAIL repress_jogada: got %b expected 0001", jogada);
    else passed++;
    botoes = 4'b0000;
    run(10);
  endtask

  task automatic test_reset_mid_hold();
    botoes = 4'b1000;
    run(12);
    total++;
    if (db_estado !== 3'd3 || jogada !== 4'b1000)
      $display("FAIL midhold_before: got state %0d jogada %b expected 3 1000", db_estado, jogada);
    else passed++;
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    total++;
    if (jogada !== 4'b0000 || db_estado !== 3'd0)
      $display("FAIL midhold_reset: got jogada %b state %0d expected 0000 0", jogada, db_estado);
    else passed++;
    run(12);
    total++;
    if (n_tem !== 1) $display("FAIL midhold_refire: got %0d expected 1", n_tem);
    else passed++;
    total++;
    if (jogada !== 4'b1000) $display("FAIL midhold_jogada: got %b expected 1000", jogada);
    else passed++;
    botoes = 4'b0000;
    run(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_invalid();
    test_auto_repeat();
    test_simultaneous();
    test_enable_gating();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
